// File: rtl/accumulator_memory_pkg.sv
// Shared encodings for the accumulator operand store: op bus codes, FSM states,
// per-processor phase values and the data width.
package accumulator_memory_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        GRANT   = 4'b0010,
        ACK     = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    localparam logic [1:0] PH_FETCH0 = 2'd0;
    localparam logic [1:0] PH_FETCH1 = 2'd1;
    localparam logic [1:0] PH_SEND   = 2'd2;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return (p == PH_SEND) ? PH_FETCH0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/accumulator_memory_rr_arbiter.sv
// Round-robin arbiter over an eligibility mask; search starts one past the last winner.
// Combinational grant; the last-winner pointer moves only when take is asserted.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  elig,
    input  logic          take,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] sel
);

    logic [PW-1:0] last;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        sel   = last;
        idx   = last;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                sel      = idx;
                found    = 1'b1;
            end
        end
    end

    // Reset to the highest index so the first search begins at processor 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= PW'(N - 1);
        else if (take && found)
            last <= sel;
    end

endmodule

// File: rtl/accumulator_memory.sv
// LIFO operand store plus bus controller serving FETCH/SEND from N accumulator processors.
// Grant is registered; signal follows a sampled op by one cycle and grant drops one cycle later.
module accumulator_memory
    import accumulator_memory_pkg::*;
#(
    parameter int N_PROC = 4,
    parameter int DEPTH  = 64,
    parameter int CW     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PROC-1:0] req,
    output logic [N_PROC-1:0] grant,
    input  logic [1:0]        op,
    output logic              signal,
    output logic [DATA_W-1:0] read,
    input  logic [DATA_W-1:0] write,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    output logic [CW-1:0]     count,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int AW = $clog2(DEPTH);

    state_t              state, state_nxt;
    logic [1:0]          phase [N_PROC];
    logic [PW-1:0]       cur, arb_sel;
    logic [N_PROC-1:0]   elig, arb_gnt;
    logic                take, do_pop, do_push;
    logic                pop_ok, push_ok, ph_zero;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [AW-1:0]       top_idx, push_idx, push2_idx;
    logic                wr0_en, wr1_en, ovf_set;
    logic [AW-1:0]       wr0_idx, wr1_idx;
    logic [CW-1:0]       count_nxt;

    // Phase 0 needs a pair on hand so a processor never strands one operand.
    always_comb begin
        for (int i = 0; i < N_PROC; i++) begin
            elig[i] = req[i] && ((phase[i] == PH_SEND) ||
                                 (phase[i] == PH_FETCH1 && count >= CW'(1)) ||
                                 (phase[i] == PH_FETCH0 && count >= CW'(2)));
        end
    end

    rr_arbiter #(.N(N_PROC), .PW(PW)) u_arb (
        .clk   (clk),
        .reset (reset),
        .elig  (elig),
        .take  (take),
        .gnt   (arb_gnt),
        .sel   (arb_sel)
    );

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    take      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                case (op)
                    OP_FETCH: begin
                        do_pop    = 1'b1;
                        state_nxt = ACK;
                    end
                    OP_SEND: begin
                        do_push   = 1'b1;
                        state_nxt = ACK;
                    end
                    default: ;
                endcase
            end
            ACK:     state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            signal <= 1'b0;
            read   <= '0;
            cur    <= '0;
            for (int i = 0; i < N_PROC; i++) phase[i] <= PH_FETCH0;
        end else begin
            state  <= state_nxt;
            signal <= do_pop | do_push;
            if (take) begin
                grant <= arb_gnt;
                cur   <= arb_sel;
            end
            if (state == ACK) begin
                grant      <= '0;
                phase[cur] <= next_phase(phase[cur]);
            end
            if (pop_ok)
                read <= mem[top_idx];
        end
    end

    assign top_idx   = AW'(count - CW'(1));
    assign push_idx  = AW'(count);
    assign push2_idx = AW'(count + CW'(1));
    assign pop_ok    = do_pop && (count != '0);
    assign push_ok   = do_push && (count != CW'(DEPTH));

    // A load beside a pop reuses the popped slot; beside a push it lands above the SEND word.
    always_comb begin
        wr0_en    = 1'b0;
        wr0_idx   = push_idx;
        wr1_en    = 1'b0;
        wr1_idx   = push_idx;
        count_nxt = count;
        ovf_set   = 1'b0;
        if (pop_ok) begin
            if (load_en) begin
                wr1_en  = 1'b1;
                wr1_idx = top_idx;
            end else begin
                count_nxt = count - CW'(1);
            end
        end else if (push_ok) begin
            wr0_en = 1'b1;
            if (load_en && count <= CW'(DEPTH - 2)) begin
                wr1_en    = 1'b1;
                wr1_idx   = push2_idx;
                count_nxt = count + CW'(2);
            end else begin
                ovf_set   = load_en;
                count_nxt = count + CW'(1);
            end
        end else if (load_en) begin
            if (count != CW'(DEPTH)) begin
                wr1_en    = 1'b1;
                count_nxt = count + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_idx] <= write;
        if (wr1_en) mem[wr1_idx] <= load_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            overflow <= overflow | ovf_set;
        end
    end

    always_comb begin
        ph_zero = 1'b1;
        for (int i = 0; i < N_PROC; i++)
            if (phase[i] != PH_FETCH0) ph_zero = 1'b0;
    end

    assign done   = (count == CW'(1)) && ph_zero && (state == IDLE) && (grant == '0);
    assign result = mem[0];

endmodule

// File: doc/accumulator_memory.md
Name: accumulator_memory

Overview:
- Shared operand store and bus controller that feeds N accumulator processors and consumes their results.
- Arbitrates the shared bus among processor requests.
- Serves FETCH by popping an operand onto `read`; absorbs SEND by pushing `write` back into the store.
- Raises `done` when the reduction has collapsed to a single value.

Parameters:
- N_PROC, 4, number of attached processors (req/grant width)
- DEPTH, 64, operand store capacity in 32-bit words
- CW, 7, count width (must satisfy 2^CW > DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_PROC  per-processor bus request
- grant  out  N_PROC  one-hot bus grant
- op  in  2  shared op bus: 01 FETCH, 10 SEND; any other value (incl. z/x) means none
- signal  out  1  one-cycle transaction-complete strobe
- read  out  32  operand to processors, valid while signal=1
- write  in  32  result from the granted processor, sampled when op=SEND
- load_en  in  1  push load_data into the store (initial operand loading)
- load_data  in  32  operand to load
- count  out  CW  words currently in the store
- done  out  1  count==1, all phases 0, bus idle
- result  out  32  store[0]; meaningful when done=1
- overflow  out  1  sticky: load_en while count==DEPTH (load dropped)

Behaviour:
- Reset (reset=0, async): grant=0, signal=0, read=0, count=0, overflow=0, all phase counters=0, FSM=IDLE. Store contents are don't-care.
- Store is a LIFO: push writes store[count] then count+1; pop returns store[count-1] then count-1.
- Per-processor phase counter (0,1,2) advances mod 3 on each completed transaction of that processor. Phases 0 and 1 are FETCH; phase 2 is SEND.
- Eligibility for processor i: req[i]=1 and one of:
  - phase 2;
  - phase 1 and count>=1;
  - phase 0 and count>=2.
- The phase-0 rule reserves a pair, which prevents deadlock with operands stranded in processors.
- FSM:
  - IDLE: round-robin pick among eligible requesters, starting after the last granted index. If any are eligible, register grant one-hot and go to GRANT; otherwise stay.
  - GRANT: hold grant. Sampled op==FETCH: register read<=pop, signal<=1, go to ACK. Sampled op==SEND: push write, signal<=1, go to ACK. Otherwise wait.
  - ACK: signal=1 for exactly this cycle, grant held. Advance the grantee's phase. Next state RELEASE, with signal<=0 and grant<=0.
  - RELEASE: grant=0, signal=0. Go to IDLE (gives the processor one cycle for req to fall).
- Latency: minimum grant-to-signal is 2 cycles, because processors drive op one cycle after seeing grant.
- Loads:
  - load_en is accepted in any state.
  - A load coincident with a FETCH pop: the pop takes store[count-1] pre-load, the load writes at the same index, count unchanged.
  - A load coincident with a SEND push: both are pushed, SEND first, count+2, provided room exists. If there is no room, the load is dropped and overflow is set.
- SEND never overflows: each cycle of three transactions nets -1.
- done is combinational: count==1 and all phases==0 and FSM==IDLE and grant==0.
- Reset mid-transaction aborts immediately; the processors are reset concurrently.

Decomposition:
- Shared package holds:
  - op encodings NOP/FETCH/SEND;
  - FSM state one-hot constants IDLE/GRANT/ACK/RELEASE;
  - phase constants;
  - DATA_W=32.
- One natural sub-module, rr_arbiter: N_PROC-wide round-robin, with an eligibility mask input, a one-hot output and a last-grant pointer.

Test Plan:
- Load 4 words {1,2,3,4}, one processor running → 3 reduction passes. Final done=1, count=1, result=10, overflow=0.
- Load {5,7}, two processors requesting simultaneously. P0 gets both fetches; P1 is not granted while count<2. P0 sends 12 → done=1, result=12.
- Single FETCH with count=3 (top=9): grant at T, op=01 seen at T+2. signal=1 at T+3 with read=9 on the same cycle. grant=0 at T+4, count=2.
- Load 8 equal values 1 with 4 processors, random slowdowns → terminates with result=8 and no deadlock. Every signal pulse coincides with exactly one grant bit.
- Fill to DEPTH, then pulse load_en → overflow=1 sticky and count stays at DEPTH.
- Assert reset low mid-GRANT → grant=0, signal=0, count=0 asynchronously, before the next clk edge.
